// File: rtl/pll_drp_ctrl.sv
// Runtime CLKOUTn divide reconfiguration for a PLLE2_ADV through its DRP port.
// Holds the PLL in reset, read-modify-writes the two CLKOUTn registers, then waits for lock.
module pll_drp_ctrl #(
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int RST_HOLD     = 8
) (
  input  logic        IO_CLK,
  input  logic        IO_RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_out_sel,
  input  logic [7:0]  req_divide,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        pll_rst,
  input  logic        pll_locked,
  output logic        locked_ok
);

  localparam int MAX_A = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int MAX_T = (MAX_A > RST_HOLD) ? MAX_A : RST_HOLD;
  localparam int CW    = $clog2(MAX_T + 1);

  // state     | meaning
  // IDLE      | ready for a request
  // CHECK     | validate latched arguments
  // HOLD      | PLL held in reset before DRP traffic
  // RDx/WRx   | one-cycle DRP access strobe
  // WT_x      | waiting for drp_drdy (timeout guarded)
  // RELEASE   | PLL reset dropped
  // WAIT_LOCK | waiting for synchronised LOCKED
  // FIN       | done pulse, err valid
  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_HOLD,
    S_RD1, S_WT_RD1, S_WR1, S_WT_WR1,
    S_RD2, S_WT_RD2, S_WR2, S_WT_WR2,
    S_RELEASE, S_WAIT_LOCK, S_FIN
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_ign;
  logic [2:0]      r_sel;
  logic [7:0]      r_div;
  logic [1:0]      r_err_pend;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;
  logic [1:0]      r_err;
  logic [6:0]      r_daddr;
  logic            r_den;
  logic            r_dwe;
  logic [15:0]     r_di;
  logic            r_pll_rst;
  logic            r_lk1;
  logic            r_lk2;
  logic            r_locked_ok;

  logic            w_accept;
  logic            w_bad;
  logic            w_tc;
  logic            w_nocount;
  logic [5:0]      w_high;
  logic [5:0]      w_low;
  logic [6:0]      w_addr1;
  logic [6:0]      w_addr2;
  logic [15:0]     w_reg1_new;
  logic [15:0]     w_reg2_new;

  assign w_accept  = req_valid & r_ready;
  assign w_bad     = (r_sel > 3'd5) | (r_div == 8'd0) | (r_div > 8'd128);
  assign w_tc      = (r_cnt == '0);
  assign w_nocount = (r_div == 8'd1);

  // 6-bit fields wrap 64 to 0, so the arithmetic is done modulo 64 directly
  assign w_high     = r_div[6:1];
  assign w_low      = r_div[5:0] - r_div[6:1];
  assign w_addr1    = 7'h08 + {3'b000, r_sel, 1'b0};
  assign w_addr2    = w_addr1 | 7'h01;
  assign w_reg1_new = (drp_do & 16'hF000) | {4'h0, w_high, w_low};
  assign w_reg2_new = (drp_do & 16'hFF3F) | {8'h00, r_div[0], w_nocount, 6'b000000};

  always_ff @(posedge IO_CLK or posedge IO_RST) begin
    if (IO_RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ign       <= 2'd0;
      r_sel       <= 3'd0;
      r_div       <= 8'd0;
      r_err_pend  <= 2'd0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 2'd0;
      r_daddr     <= 7'd0;
      r_den       <= 1'b0;
      r_dwe       <= 1'b0;
      r_di        <= 16'd0;
      r_pll_rst   <= 1'b0;
      r_lk1       <= 1'b0;
      r_lk2       <= 1'b0;
      r_locked_ok <= 1'b0;
    end else begin
      r_lk1       <= pll_locked;
      r_lk2       <= r_lk1;
      r_locked_ok <= r_lk2 & ~r_busy & ~w_accept;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sel      <= req_out_sel;
            r_div      <= req_divide;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_err      <= 2'd0;
            r_err_pend <= 2'd0;
            r_state    <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (w_bad) begin
            r_done  <= 1'b1;
            r_err   <= 2'd1;
            r_state <= S_FIN;
          end else begin
            r_pll_rst <= 1'b1;
            r_cnt     <= CW'(RST_HOLD - 1);
            r_state   <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (w_tc) begin
            r_daddr <= w_addr1;
            r_den   <= 1'b1;
            r_state <= S_RD1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_RD1, S_WR1, S_RD2, S_WR2: begin
          r_den <= 1'b0;
          r_dwe <= 1'b0;
          r_cnt <= CW'(DRDY_TIMEOUT - 1);
          case (r_state)
            S_RD1:   r_state <= S_WT_RD1;
            S_WR1:   r_state <= S_WT_WR1;
            S_RD2:   r_state <= S_WT_RD2;
            default: r_state <= S_WT_WR2;
          endcase
        end

        S_WT_RD1, S_WT_WR1, S_WT_RD2, S_WT_WR2: begin
          if (drp_drdy) begin
            case (r_state)
              S_WT_RD1: begin
                r_di    <= w_reg1_new;
                r_den   <= 1'b1;
                r_dwe   <= 1'b1;
                r_state <= S_WR1;
              end
              S_WT_WR1: begin
                r_daddr <= w_addr2;
                r_den   <= 1'b1;
                r_state <= S_RD2;
              end
              S_WT_RD2: begin
                r_di    <= w_reg2_new;
                r_den   <= 1'b1;
                r_dwe   <= 1'b1;
                r_state <= S_WR2;
              end
              default: begin
                r_pll_rst <= 1'b0;
                r_state   <= S_RELEASE;
              end
            endcase
          end else if (w_tc) begin
            // abandon the DRP sequence but still let the PLL try to relock
            r_err_pend <= 2'd2;
            r_pll_rst  <= 1'b0;
            r_state    <= S_RELEASE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_RELEASE: begin
          r_cnt   <= CW'(LOCK_TIMEOUT - 1);
          r_ign   <= 2'd2;
          r_state <= S_WAIT_LOCK;
        end

        S_WAIT_LOCK: begin
          if (r_ign == 2'd0 && r_lk2) begin
            r_done  <= 1'b1;
            r_err   <= r_err_pend;
            r_state <= S_FIN;
          end else if (w_tc) begin
            r_done  <= 1'b1;
            r_err   <= (r_err_pend != 2'd0) ? r_err_pend : 2'd3;
            r_state <= S_FIN;
          end else begin
            r_cnt <= r_cnt - CW'(1);
            if (r_ign != 2'd0) r_ign <= r_ign - 2'd1;
          end
        end

        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign drp_daddr = r_daddr;
  assign drp_den   = r_den;
  assign drp_dwe   = r_dwe;
  assign drp_di    = r_di;
  assign pll_rst   = r_pll_rst;
  assign locked_ok = r_locked_ok;

endmodule
